// File: rtl/register_file_latch_arbiter.sv
// register_file_latch_arbiter
//   Front-end controller for a latch-based register file with one write port
//   and one read port. Two write requesters share the write port through
//   round-robin arbitration. The winning command is registered so that the
//   latch array sees flop-driven address, data and enable for a full cycle.
//   Reads use a valid/ready handshake and a registered return path. A read
//   stalls while it targets the address currently being written.
//
// Optional build macro: REGFILE_ARB_STATS_EN
//   When defined, the block adds saturating 16-bit counters for grants per
//   write port and for read-stall cycles.
//
// Ports
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   wr0_* / wr1_*                 write requesters (valid/ready, addr, data)
//   rd_valid_i / rd_ready_o       read request handshake
//   rd_addr_i                     read address
//   rd_rvalid_o / rd_rdata_o      registered read return (one-cycle pulse)
//   rf_waddr_o/rf_wdata_o/rf_we_o registered write command to the register file
//   rf_raddr_o / rf_rdata_i       register file read port
//   stat_*_cnt_o                  statistics (REGFILE_ARB_STATS_EN only)
module register_file_latch_arbiter #(
  parameter int unsigned AddrWidth = 4,
  parameter int unsigned DataWidth = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 wr0_valid_i,
  output logic                 wr0_ready_o,
  input  logic [AddrWidth-1:0] wr0_addr_i,
  input  logic [DataWidth-1:0] wr0_data_i,
  input  logic                 wr1_valid_i,
  output logic                 wr1_ready_o,
  input  logic [AddrWidth-1:0] wr1_addr_i,
  input  logic [DataWidth-1:0] wr1_data_i,
  input  logic                 rd_valid_i,
  output logic                 rd_ready_o,
  input  logic [AddrWidth-1:0] rd_addr_i,
  output logic                 rd_rvalid_o,
  output logic [DataWidth-1:0] rd_rdata_o,
  output logic [AddrWidth-1:0] rf_waddr_o,
  output logic [DataWidth-1:0] rf_wdata_o,
  output logic                 rf_we_o,
  output logic [AddrWidth-1:0] rf_raddr_o,
  input  logic [DataWidth-1:0] rf_rdata_i
`ifdef REGFILE_ARB_STATS_EN
  ,
  output logic [15:0]          stat_wr0_cnt_o,
  output logic [15:0]          stat_wr1_cnt_o,
  output logic [15:0]          stat_stall_cnt_o
`endif
);

  typedef enum logic {
    PORT0 = 1'b0,
    PORT1 = 1'b1
  } port_e;

  port_e last_grant_q;
  logic  gnt0;
  logic  gnt1;
  logic  rd_collision;

  // Round-robin: on contention the port that did not win last time is served.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (wr0_valid_i && wr1_valid_i) begin
      if (last_grant_q == PORT1) begin
        gnt0 = 1'b1;
      end else begin
        gnt1 = 1'b1;
      end
    end else begin
      gnt0 = wr0_valid_i;
      gnt1 = wr1_valid_i;
    end
  end

  assign wr0_ready_o = gnt0;
  assign wr1_ready_o = gnt1;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_grant_q <= PORT1;
    end else if (gnt0) begin
      last_grant_q <= PORT0;
    end else if (gnt1) begin
      last_grant_q <= PORT1;
    end
  end

  // Registered write command; address/data hold when nothing is granted.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rf_we_o    <= 1'b0;
      rf_waddr_o <= '0;
      rf_wdata_o <= '0;
    end else begin
      rf_we_o <= gnt0 | gnt1;
      if (gnt0) begin
        rf_waddr_o <= wr0_addr_i;
        rf_wdata_o <= wr0_data_i;
      end else if (gnt1) begin
        rf_waddr_o <= wr1_addr_i;
        rf_wdata_o <= wr1_data_i;
      end
    end
  end

  // A read hitting the word the latch array is writing this cycle would see
  // transparent/unstable data, so it is held off until the write completes.
  assign rf_raddr_o   = rd_addr_i;
  assign rd_collision = rf_we_o && (rf_waddr_o == rd_addr_i);
  assign rd_ready_o   = rd_valid_i && !rd_collision;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_rvalid_o <= 1'b0;
      rd_rdata_o  <= '0;
    end else begin
      rd_rvalid_o <= rd_ready_o;
      if (rd_ready_o) begin
        rd_rdata_o <= rf_rdata_i;
      end
    end
  end

`ifdef REGFILE_ARB_STATS_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stat_wr0_cnt_o   <= '0;
      stat_wr1_cnt_o   <= '0;
      stat_stall_cnt_o <= '0;
    end else begin
      if (gnt0 && (stat_wr0_cnt_o != '1)) begin
        stat_wr0_cnt_o <= stat_wr0_cnt_o + 16'd1;
      end
      if (gnt1 && (stat_wr1_cnt_o != '1)) begin
        stat_wr1_cnt_o <= stat_wr1_cnt_o + 16'd1;
      end
      if (rd_valid_i && !rd_ready_o && (stat_stall_cnt_o != '1)) begin
        stat_stall_cnt_o <= stat_stall_cnt_o + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_register_file_latch_arbiter.sv
// Self-checking bench for register_file_latch_arbiter. A simple register file
// array sits behind the DUT; a behavioural model predicts handshakes and data.
module tb_register_file_latch_arbiter;

  logic        clk;
  logic        rst_ni;
  logic        wr0_valid, wr0_ready, wr1_valid, wr1_ready;
  logic [3:0]  wr0_addr, wr1_addr, rd_addr, rf_waddr, rf_raddr;
  logic [15:0] wr0_data, wr1_data, rd_rdata, rf_wdata, rf_rdata;
  logic        rd_valid, rd_ready, rd_rvalid, rf_we;
`ifdef REGFILE_ARB_STATS_EN
  logic [15:0] stat_wr0, stat_wr1, stat_stall;
`endif

  register_file_latch_arbiter #(.AddrWidth(4), .DataWidth(16)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .wr0_valid_i(wr0_valid), .wr0_ready_o(wr0_ready),
    .wr0_addr_i(wr0_addr), .wr0_data_i(wr0_data),
    .wr1_valid_i(wr1_valid), .wr1_ready_o(wr1_ready),
    .wr1_addr_i(wr1_addr), .wr1_data_i(wr1_data),
    .rd_valid_i(rd_valid), .rd_ready_o(rd_ready), .rd_addr_i(rd_addr),
    .rd_rvalid_o(rd_rvalid), .rd_rdata_o(rd_rdata),
    .rf_waddr_o(rf_waddr), .rf_wdata_o(rf_wdata), .rf_we_o(rf_we),
    .rf_raddr_o(rf_raddr), .rf_rdata_i(rf_rdata)
`ifdef REGFILE_ARB_STATS_EN
    , .stat_wr0_cnt_o(stat_wr0), .stat_wr1_cnt_o(stat_wr1),
    .stat_stall_cnt_o(stat_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file stand-in: combinational read, write lands at the clock edge.
  logic [15:0] rf_mem [16];
  always @(posedge clk) if (rf_we) rf_mem[rf_waddr] <= rf_wdata;
  assign rf_rdata = rf_mem[rf_raddr];

  // Reference model state
  logic [15:0] ref_mem [16];
  int          m_last;
  logic        m_we, m_rvalid;
  logic [3:0]  m_waddr;
  logic [15:0] m_wdata, m_rdata;
  int          m_s0, m_s1, m_ss;
  logic        got_g0, got_g1, got_rr;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_last = 1; m_we = 1'b0; m_waddr = '0; m_wdata = '0;
    m_rvalid = 1'b0; m_rdata = '0;
    m_s0 = 0; m_s1 = 0; m_ss = 0;
  endtask

  // One cycle: drive, check combinational handshakes, advance, check registers.
  task automatic step(input logic v0, input logic [3:0] a0, input logic [15:0] d0,
                      input logic v1, input logic [3:0] a1, input logic [15:0] d1,
                      input logic rv, input logic [3:0] ra);
    logic e_g0, e_g1, e_rr;
    wr0_valid = v0; wr0_addr = a0; wr0_data = d0;
    wr1_valid = v1; wr1_addr = a1; wr1_data = d1;
    rd_valid = rv; rd_addr = ra;
    #2;
    e_g0 = v0 && (!v1 || m_last == 1);
    e_g1 = v1 && (!v0 || m_last == 0);
    e_rr = rv && !(m_we && m_waddr == ra);
    chk("wr0_ready", 32'(wr0_ready), 32'(e_g0));
    chk("wr1_ready", 32'(wr1_ready), 32'(e_g1));
    chk("rd_ready", 32'(rd_ready), 32'(e_rr));
    chk("rf_raddr", 32'(rf_raddr), 32'(ra));
    got_g0 = wr0_ready; got_g1 = wr1_ready; got_rr = rd_ready;
    if (e_g0) m_s0++;
    if (e_g1) m_s1++;
    if (rv && !e_rr) m_ss++;
    m_rvalid = e_rr;
    if (e_rr) m_rdata = ref_mem[ra];
    if (m_we) ref_mem[m_waddr] = m_wdata;
    m_we = e_g0 || e_g1;
    if (e_g0) begin m_waddr = a0; m_wdata = d0; m_last = 0; end
    else if (e_g1) begin m_waddr = a1; m_wdata = d1; m_last = 1; end
    @(posedge clk); #1;
    chk("rf_we", 32'(rf_we), 32'(m_we));
    chk("rf_waddr", 32'(rf_waddr), 32'(m_waddr));
    chk("rf_wdata", 32'(rf_wdata), 32'(m_wdata));
    chk("rd_rvalid", 32'(rd_rvalid), 32'(m_rvalid));
    chk("rd_rdata", 32'(rd_rdata), 32'(m_rdata));
  endtask

  task automatic idle();
    step(1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 16'd0, 1'b0, 4'd0);
  endtask

  initial begin
    logic [3:0] exp_gnt1;
    for (int i = 0; i < 16; i++) begin
      rf_mem[i] = 16'($urandom);
      ref_mem[i] = rf_mem[i];
    end
    model_reset();
    rst_ni = 1'b0;
    wr0_valid = 0; wr1_valid = 0; rd_valid = 0;
    wr0_addr = 0; wr1_addr = 0; rd_addr = 0; wr0_data = 0; wr1_data = 0;
    #1;
    chk("reset_rf_we", 32'(rf_we), 32'd0);
    chk("reset_waddr", 32'(rf_waddr), 32'd0);
    chk("reset_wdata", 32'(rf_wdata), 32'd0);
    chk("reset_rvalid", 32'(rd_rvalid), 32'd0);
    chk("reset_rdata", 32'(rd_rdata), 32'd0);
    @(posedge clk); @(negedge clk);
    rst_ni = 1'b1;
    @(posedge clk); #1;

    // Contention straight after reset: 0,1,0,1 with continuous write enable
    exp_gnt1 = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 4'(i), 16'(16'h100 + i), 1'b1, 4'(i + 8), 16'(16'h200 + i), 1'b0, 4'd0);
      chk("contend_gnt1", 32'(got_g1), 32'(exp_gnt1[i]));
      chk("contend_we", 32'(rf_we), 32'd1);
    end
    idle();

    // Single wr0 write
    step(1'b1, 4'd3, 16'h1234, 1'b0, 4'd0, 16'd0, 1'b0, 4'd0);
    chk("w3_ready", 32'(got_g0), 32'd1);
    chk("w3_addr", 32'(rf_waddr), 32'd3);
    chk("w3_data", 32'(rf_wdata), 32'h1234);
    idle();
    chk("w3_we_off", 32'(rf_we), 32'd0);

    // Collision: write 5 <= -7, then read 5 stalls one cycle
    step(1'b1, 4'd5, 16'hFFF9, 1'b0, 4'd0, 16'd0, 1'b0, 4'd0);
    step(1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 16'd0, 1'b1, 4'd5);
    chk("coll_stall", 32'(got_rr), 32'd0);
    step(1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 16'd0, 1'b1, 4'd5);
    chk("coll_accept", 32'(got_rr), 32'd1);
    chk("coll_rvalid", 32'(rd_rvalid), 32'd1);
    chk("coll_rdata", 32'(rd_rdata), 32'hFFF9);

    // Independent read of 2 and write of 9 in the same cycle
    step(1'b0, 4'd0, 16'd0, 1'b1, 4'd9, 16'h0999, 1'b1, 4'd2);
    chk("indep_rd", 32'(got_rr), 32'd1);
    chk("indep_wr", 32'(got_g1), 32'd1);
    idle();

    // Async reset while a write is on the RF port
    step(1'b1, 4'd7, 16'h7777, 1'b0, 4'd0, 16'd0, 1'b0, 4'd0);
    chk("pre_rst_we", 32'(rf_we), 32'd1);
    #2;
    rst_ni = 1'b0;
    wr0_valid = 0; wr1_valid = 0; rd_valid = 0;
    #1;
    chk("async_we", 32'(rf_we), 32'd0);
    chk("async_waddr", 32'(rf_waddr), 32'd0);
    chk("async_rvalid", 32'(rd_rvalid), 32'd0);
    model_reset();
    @(negedge clk);
    rst_ni = 1'b1;
    @(posedge clk); #1;
    step(1'b0, 4'd0, 16'd0, 1'b1, 4'd4, 16'h4444, 1'b0, 4'd0);
    chk("post_rst_wr1", 32'(got_g1), 32'd1);
    step(1'b1, 4'd6, 16'h6666, 1'b1, 4'd7, 16'h7070, 1'b1, 4'd7);
    chk("post_rst_gnt0", 32'(got_g0), 32'd1);

    // Randomized traffic on a narrow address range to provoke collisions
    for (int n = 0; n < 400; n++) begin
      step(1'($urandom), 4'($urandom_range(0, 3)), 16'($urandom),
           1'($urandom), 4'($urandom_range(0, 3)), 16'($urandom),
           1'($urandom), 4'($urandom_range(0, 3)));
    end
    idle();

`ifdef REGFILE_ARB_STATS_EN
    chk("stat_wr0", 32'(stat_wr0), 32'(m_s0));
    chk("stat_wr1", 32'(stat_wr1), 32'(m_s1));
    chk("stat_stall", 32'(stat_stall), 32'(m_ss));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
